both_edge_detector: RTL and testbench
=====================================

# both_edge_detector

Per-bit rising- and falling-edge detector for level signals sampled on a single clock. On each clock edge, every input bit is compared with its value from the previous edge. A detected rising transition raises a one-cycle pulse on `pos_edge_out`; a detected falling transition raises a one-cycle pulse on `neg_edge_out`. The block sits between slow or level-type control inputs and downstream logic that needs single-cycle event strobes.

## Interface
- `WIDTH`, default 1: number of independent input bits, each detected separately.
- `SYNC_STAGES`, default 2, legal range 2..4: synchronizer depth. Used only when `BOTH_EDGE_SYNC_EN` is defined.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `signal_in`  input  WIDTH  level input(s) to monitor.
- `pos_edge_out`  output  WIDTH  registered one-cycle strobe per bit on a 0→1 transition.
- `neg_edge_out`  output  WIDTH  registered one-cycle strobe per bit on a 1→0 transition.

## Operation
- Sampled value `d`:
  - `signal_in` directly, or
  - the last synchronizer stage when `BOTH_EDGE_SYNC_EN` is defined.
- State per bit:
  - `prev`: the sample taken at the previous clock edge.
  - One shared `armed` flag.
- On each posedge while `rst_n` is high:
  - `prev <= d`.
  - `armed <= 1`.
  - If `armed` is 1: `pos_edge_out <= d & ~prev` and `neg_edge_out <= ~d & prev`.
  - If `armed` is 0: both outputs `<= 0`. This is the first edge after reset; no edge is reported, so a high input at reset release does not produce a spurious pulse.
- Bits are fully independent. Several bits may pulse on the same cycle.
- For any one bit, `pos_edge_out` and `neg_edge_out` are never high together.
- Input pulses shorter than one clock period that fall between two sampling edges are not detected. This is required behaviour, not an error.
- A bit that toggles on every sampling edge produces alternating pos/neg strobes on consecutive cycles.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `pos_edge_out = 0`, `neg_edge_out = 0`.
  - `prev = 0`, `armed = 0`.
  - All synchronizer flops = 0.
- Reset release must be synchronized externally to `clk`.
- Latency without sync: a transition on `signal_in` before posedge N (setup met) gives an output strobe that goes high at posedge N and falls at posedge N+1. The strobe is exactly one clock period wide.
- Latency with sync: add `SYNC_STAGES` cycles.
- Reset asserted mid-pulse: outputs clear immediately. After release, the first edge re-arms the detector and reports no edge.
- Outputs are driven directly from flops; there is no combinational path from input to output.

## Configuration
- Macro: `BOTH_EDGE_SYNC_EN`.
- When defined:
  - `signal_in` passes through a `SYNC_STAGES`-deep flop chain per bit, reset to 0, before detection.
  - Use this for asynchronous inputs.
- When undefined:
  - `signal_in` must be synchronous to `clk` and is sampled directly.
  - `SYNC_STAGES` is ignored.

## Test plan
All scenarios: `WIDTH=1`, no sync, 10 ns clock, rising edges at 5, 15, 25, … ns; reset released at 3 ns unless stated otherwise.
- **Basic rise/fall.** Stimulus: `signal_in` goes 0→1 at 12 ns and 1→0 at 22 ns. Required: `pos_edge_out` = 1 from 15 to 25 ns; `neg_edge_out` = 1 from 25 to 35 ns; both 0 elsewhere.
- **Held high.** Stimulus: input rises at 32 ns and is held high over the 35, 45 and 55 ns edges. Required: a single `pos_edge_out` strobe over 35–45 ns; no strobe at 45 or 55 ns.
- **High at reset release.** Stimulus: `signal_in` = 1 throughout; `rst_n` released at 3 ns. Required: no `pos_edge_out` at any edge; both outputs stay 0.
- **Asynchronous reset mid-strobe.** Stimulus: `pos_edge_out` is high; pull `rst_n` low at 18 ns. Required: outputs are 0 by 18 ns, independent of the clock; after release, the first edge produces no strobe.
- **Sub-cycle glitch.** Stimulus: input high only from 16 to 23 ns, so no sampling edge sees it. Required: no strobes.
- **Multi-bit and sync build.** Stimulus: `WIDTH=4`, `BOTH_EDGE_SYNC_EN` defined, `SYNC_STAGES=2`; `signal_in` goes 0000→0101 at 12 ns. Required: `pos_edge_out` = 0101 from 35 to 45 ns; `neg_edge_out` = 0000 throughout.

Source files
------------

// File: rtl/both_edge_detector.sv
// both_edge_detector: per-bit rising/falling edge strobes on level inputs.
// Define BOTH_EDGE_SYNC_EN to pass signal_in through a SYNC_STAGES-deep synchronizer first.
module both_edge_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] signal_in,
    output logic [WIDTH-1:0] pos_edge_out,
    output logic [WIDTH-1:0] neg_edge_out
);
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] r_prev;
    logic             r_armed;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("SYNC_STAGES must be in 2..4");
    end

`ifdef BOTH_EDGE_SYNC_EN
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in};
    end

    assign w_d = r_sync[SYNC_STAGES-1];
`else
    assign w_d = signal_in;
`endif

    // The first edge after reset only arms, so a level already high at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_armed      <= 1'b0;
            pos_edge_out <= '0;
            neg_edge_out <= '0;
        end else begin
            r_prev       <= w_d;
            r_armed      <= 1'b1;
            pos_edge_out <= r_armed ? (w_d & ~r_prev) : '0;
            neg_edge_out <= r_armed ? (~w_d & r_prev) : '0;
        end
    end
endmodule

// File: tb/tb_both_edge_detector.sv
// tb_both_edge_detector: directed checks of a 1-bit and a 4-bit edge detector on a 10 ns clock.
module tb_both_edge_detector;
`ifdef BOTH_EDGE_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s1;
    logic [3:0] s4;
    logic       pos1, neg1;
    logic [3:0] pos4, neg4;
    int         total = 0;
    int         bad = 0;

    both_edge_detector #(.WIDTH(1)) dut (
        .clk(clk), .rst_n(rst_n), .signal_in(s1),
        .pos_edge_out(pos1), .neg_edge_out(neg1)
    );

    both_edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .signal_in(s4),
        .pos_edge_out(pos4), .neg_edge_out(neg4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rst_n = 1'b0; s1 = 1'b0; s4 = 4'b0000;
        #1;  // t=1
        chk("rst_pos1", pos1, 0); chk("rst_neg1", neg1, 0);
        chk("rst_pos4", pos4, 0); chk("rst_neg4", neg4, 0);
        #2 rst_n = 1'b1;                      // t=3
        #9 s1 = 1'b1; s4 = 4'b0101;           // t=12
        #8;  // t=20
        chk("rise_pos", pos1, 1); chk("rise_neg", neg1, 0);
        chk("mb_pos_a", pos4, SYNC ? 4'b0000 : 4'b0101);
        #2 s1 = 1'b0;                         // t=22
        #8;  // t=30
        chk("fall_pos", pos1, 0); chk("fall_neg", neg1, 1);
        #10; // t=40
        chk("idle_pos", pos1, 0); chk("idle_neg", neg1, 0);
        chk("mb_pos_b", pos4, SYNC ? 4'b0101 : 4'b0000); chk("mb_neg_b", neg4, 0);
        #2 s1 = 1'b1; s4 = 4'b0110;           // t=42
        #8;  // t=50
        chk("hold_pos0", pos1, 1); chk("hold_neg0", neg1, 0);
        chk("mb_pos_c", pos4, SYNC ? 4'b0000 : 4'b0010);
        chk("mb_neg_c", neg4, SYNC ? 4'b0000 : 4'b0001);
        #10; // t=60
        chk("hold_pos1", pos1, 0); chk("hold_neg1", neg1, 0);
        chk("mb_pos_d", pos4, 0); chk("mb_neg_d", neg4, 0);
        #10; // t=70
        chk("hold_pos2", pos1, 0); chk("hold_neg2", neg1, 0);
        chk("mb_pos_e", pos4, SYNC ? 4'b0010 : 4'b0000);
        chk("mb_neg_e", neg4, SYNC ? 4'b0001 : 4'b0000);
        #2 s1 = 1'b0;                         // t=72
        #8;  // t=80
        chk("tog_neg", neg1, 1);
        #2 s1 = 1'b1;                         // t=82
        #8;  // t=90
        chk("tog_pos", pos1, 1); chk("tog_neg0", neg1, 0);
        #1;  // t=91, mid-strobe
        chk("pre_rst_pos", pos1, 1);
        rst_n = 1'b0;
        #1;  // t=92, no clock edge since reset asserted
        chk("arst_pos1", pos1, 0); chk("arst_neg1", neg1, 0);
        chk("arst_pos4", pos4, 0); chk("arst_neg4", neg4, 0);
        #1 rst_n = 1'b1;                      // t=93, s1 held high
        #7;  // t=100
        chk("rel_pos0", pos1, 0); chk("rel_neg0", neg1, 0);
        #10; // t=110
        chk("rel_pos1", pos1, 0); chk("rel_neg1", neg1, 0);
        #10; // t=120
        chk("rel_pos2", pos1, 0); chk("rel_neg2", neg1, 0);
        #6 s1 = 1'b0;                         // t=126, low glitch between edges
        #7 s1 = 1'b1;                         // t=133
        #7;  // t=140
        chk("lglitch_pos", pos1, 0); chk("lglitch_neg", neg1, 0);
        #2 s1 = 1'b0;                         // t=142
        #8;  // t=150
        chk("pre_glitch_neg", neg1, 1);
        #6 s1 = 1'b1;                         // t=156, high glitch between edges
        #7 s1 = 1'b0;                         // t=163
        #7;  // t=170
        chk("hglitch_pos", pos1, 0); chk("hglitch_neg", neg1, 0);
        #10; // t=180
        chk("hglitch_pos2", pos1, 0); chk("hglitch_neg2", neg1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
